ecall_io_controller: RTL and testbench

- Board-side I/O responder for the CPU's ecall interface.
- Print path: consumes the register file's print request and value, latches the value, and shows it as 8 hex digits on a multiplexed seven-segment display.
- Read path: services the read-integer request by stalling the CPU until the user sets switches and presses a debounced confirm button, then returns the switch value on io_input.

---
 rtl/ecall_io_controller.sv | 176 +++++++++++++++++
 tb/tb_ecall_io_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ecall_io_controller.sv
// Ecall I/O responder: latches print values onto a multiplexed 8-digit
// seven-segment display and services read-integer ecalls from switches + button.
//
// state        | meaning
// IDLE         | no read pending
// WAIT_PRESS   | read requested, CPU stalled, waiting for a debounced press
// WAIT_RELEASE | switches captured, waiting for the button to be released
// DONE         | io_input valid for one cycle, CPU released
module ecall_io_controller #(
  parameter int SW_WIDTH        = 16,
  parameter bit SIGN_EXTEND     = 1'b1,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                print_req,
  input  logic [31:0]         print_data,
  input  logic                read_req,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                confirm_btn,
  output logic [31:0]         io_input,
  output logic                input_valid,
  output logic                cpu_stall,
  output logic [7:0]          seg_an,
  output logic [7:0]          seg_data,
  output logic [31:0]         display_value
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             btn_meta, btn_sync;
  logic             btn_deb, btn_deb_q;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_press;

  logic             print_req_q;

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit_idx;

  logic        capture;
  logic [31:0] sw_ext;

  // Button: two-flop synchroniser, then a stability counter on the level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      btn_deb   <= 1'b0;
      btn_deb_q <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      btn_meta  <= confirm_btn;
      btn_sync  <= btn_meta;
      btn_deb_q <= btn_deb;
      if (btn_sync == btn_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_deb <= btn_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign btn_press = btn_deb & ~btn_deb_q;

  // Print latch on the rising edge of print_req, regardless of read state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      print_req_q   <= 1'b0;
      display_value <= '0;
    end else begin
      print_req_q <= print_req;
      if (print_req && !print_req_q) display_value <= print_data;
    end
  end

  always_comb begin
    if (SIGN_EXTEND) sw_ext = 32'($signed(switches));
    else             sw_ext = 32'(switches);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      io_input <= '0;
    end else begin
      state_q <= state_d;
      if (capture) io_input <= sw_ext;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:         if (read_req) state_d = WAIT_PRESS;
      WAIT_PRESS: begin
        if (btn_press) begin
          capture = 1'b1;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: if (!btn_deb) state_d = DONE;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Stall is combinational so the CPU holds in the request cycle itself.
  assign cpu_stall   = ((state_q == IDLE) && read_req) ||
                       (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
  assign input_valid = (state_q == DONE);

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Anode and segment registers trail the digit index by one clock, together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_an   <= 8'hFE;
      seg_data <= 8'hC0;
    end else begin
      seg_an   <= ~(8'd1 << digit_idx);
      seg_data <= hex_seg(display_value[{digit_idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_ecall_io_controller.sv
// Randomised scoreboard bench for ecall_io_controller: two instances (sign- and
// zero-extending) share stimulus; a cycle model tracks the display scan.
module tb_ecall_io_controller;

  localparam int SWW  = 16;
  localparam int DEB  = 4;
  localparam int SCAN = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        print_req = 1'b0;
  logic [31:0] print_data = '0;
  logic        read_req = 1'b0;
  logic [SWW-1:0] switches = '0;
  logic        confirm_btn = 1'b0;

  logic [31:0] io_input0, io_input1, disp0, disp1;
  logic        iv0, iv1, st0, st1;
  logic [7:0]  an0, an1, sd0, sd1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  ecall_io_controller #(.SW_WIDTH(SWW), .SIGN_EXTEND(1'b1),
                        .DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SCAN)) u0 (
    .clk(clk), .reset(reset), .print_req(print_req), .print_data(print_data),
    .read_req(read_req), .switches(switches), .confirm_btn(confirm_btn),
    .io_input(io_input0), .input_valid(iv0), .cpu_stall(st0),
    .seg_an(an0), .seg_data(sd0), .display_value(disp0));

  ecall_io_controller #(.SW_WIDTH(SWW), .SIGN_EXTEND(1'b0),
                        .DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SCAN)) u1 (
    .clk(clk), .reset(reset), .print_req(print_req), .print_data(print_data),
    .read_req(read_req), .switches(switches), .confirm_btn(confirm_btn),
    .io_input(io_input1), .input_valid(iv1), .cpu_stall(st1),
    .seg_an(an1), .seg_data(sd1), .display_value(disp1));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Display reference: edges since reset pick the digit; seven-seg lookup table.
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          cyc = 0;
  logic [31:0] disp_m = '0;
  logic        preq_m = 1'b0;
  logic [7:0]  exp_an = 8'hFE;
  logic [7:0]  exp_seg = 8'hC0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0; disp_m = '0; preq_m = 1'b0; exp_an = 8'hFE; exp_seg = 8'hC0;
    end else begin
      int k;
      k = (cyc / SCAN) % 8;
      exp_an  = ~(8'd1 << k);
      exp_seg = hex_tab[(disp_m >> (4 * k)) & 32'hF];
      if (print_req && !preq_m) disp_m = print_data;
      preq_m = print_req;
      cyc++;
    end
  end

  // Monitor: per-cycle display checks and scoreboard pops on input_valid.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("seg_an", {24'h0, an0}, {24'h0, exp_an});
      chk("seg_data", {24'h0, sd0}, {24'h0, exp_seg});
      chk("display0", disp0, disp_m);
      chk("display1", disp1, disp_m);
      if (iv0) begin
        if (q0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL valid0_unexpected: got input_valid=1 expected 0");
        end else chk("io_input_sext", io_input0, q0.pop_front());
        chk("stall_done0", {31'h0, st0}, 32'h0);
      end
      if (iv1) begin
        if (q1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL valid1_unexpected: got input_valid=1 expected 0");
        end else chk("io_input_zext", io_input1, q1.pop_front());
        chk("stall_done1", {31'h0, st1}, 32'h0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_print(input logic [31:0] d);
    print_data = d; print_req = 1'b1;
    tick(1);
    print_req = 1'b0;
    chk("print_latch", disp0, d);
  endtask

  task automatic wait_seg(input logic [7:0] an, input logic [7:0] seg);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (an0 == an) begin
        seen = 1'b1;
        chk("seg_digit", {24'h0, sd0}, {24'h0, seg});
      end
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL seg_wait: anode %h never seen", an);
    end
  endtask

  task automatic do_read(input logic [SWW-1:0] sw, input bit bounce,
                         input bit print_mid, input bit pre_held);
    bit got = 1'b0;
    switches = sw;
    q0.push_back({{(32-SWW){sw[SWW-1]}}, sw});
    q1.push_back({{(32-SWW){1'b0}}, sw});
    read_req = 1'b1;
    #1;
    chk("stall_req0", {31'h0, st0}, 32'h1);
    chk("stall_req1", {31'h0, st1}, 32'h1);
    tick(1);
    if (pre_held) begin
      for (int i = 0; i < 10; i++) begin tick(1); chk("stall_held", {31'h0, st0}, 32'h1); end
      confirm_btn = 1'b0;
      for (int i = 0; i < 8; i++) begin tick(1); chk("stall_unheld", {31'h0, st0}, 32'h1); end
    end
    if (bounce) begin
      confirm_btn = 1'b1; tick(1);
      confirm_btn = 1'b0; tick(1);
      confirm_btn = 1'b1; tick(1);
      confirm_btn = 1'b0;
      for (int i = 0; i < 8; i++) begin tick(1); chk("stall_bounce", {31'h0, st0}, 32'h1); end
    end
    confirm_btn = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(1); chk("stall_press", {31'h0, st0}, 32'h1); end
    if (print_mid) pulse_print($urandom);
    confirm_btn = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick(1);
      if (iv0) begin
        got = 1'b1;
        chk("stall_in_done", {31'h0, st0}, 32'h0);
        read_req = 1'b0;
      end else chk("stall_wait", {31'h0, st0}, 32'h1);
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL read_timeout: got no input_valid expected one within 30 cycles");
      read_req = 1'b0;
      q0.delete(); q1.delete();
    end
    tick(2);
  endtask

  initial begin
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_io_input", io_input0, 32'h0);
    chk("rst_stall", {31'h0, st0}, 32'h0);
    chk("rst_seg_an", {24'h0, an0}, 32'hFE);
    chk("rst_seg_data", {24'h0, sd0}, 32'hC0);
    chk("rst_display", disp0, 32'h0);
    chk("rst_valid", {31'h0, iv0}, 32'h0);
    tick(3);
    chk("scan_second_digit", {24'h0, an0}, 32'hFD);

    pulse_print(32'h1234ABCD);
    print_data = 32'h0; print_req = 1'b1;
    tick(3);
    chk("print_held_no_relatch", disp0, 32'h1234ABCD);
    print_req = 1'b0;
    tick(1);
    wait_seg(8'hFE, 8'hA1);
    wait_seg(8'h7F, 8'hF9);

    do_read(16'hFFFE, 1'b1, 1'b0, 1'b0);

    // Press in IDLE (read_req low) must not produce a response.
    confirm_btn = 1'b1; tick(8); confirm_btn = 1'b0; tick(8);

    confirm_btn = 1'b1; tick(8);
    do_read(16'($urandom), 1'b0, 1'b0, 1'b1);

    pulse_print(32'hCAFE0042);
    switches = 16'($urandom);
    read_req = 1'b1; tick(1);
    confirm_btn = 1'b1; tick(3);
    reset = 1'b0; read_req = 1'b0; confirm_btn = 1'b0;
    #1;
    chk("abort_stall", {31'h0, st0}, 32'h0);
    chk("abort_display", disp0, 32'h0);
    chk("abort_io_input", io_input0, 32'h0);
    tick(2);
    reset = 1'b1;
    tick(2);

    do_read(16'h8001, 1'b0, 1'b1, 1'b0);
    do_read(16'h7FFF, 1'b1, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 2) == 0) pulse_print($urandom);
      do_read(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    tick(4);
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
